debug_module: RTL and testbench



---
 rtl/debug_module.sv | 185 ++++++++++++++++++
 tb/tb_debug_module.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_module.sv
// RISC-V debug module (0.13 subset), DMI responder side, controlling hart 0.
// One request is accepted in IDLE and answered from RESP; abstract commands always report "not supported".
module debug_module #(
   parameter int DMI_ABITS = 7
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 dmi_req_valid,
   output logic                 dmi_req_ready,
   input  logic [DMI_ABITS-1:0] dmi_req_addr,
   input  logic [31:0]          dmi_req_data,
   input  logic [1:0]           dmi_req_op,
   output logic                 dmi_resp_valid,
   input  logic                 dmi_resp_ready,
   output logic [31:0]          dmi_resp_data,
   output logic [1:0]           dmi_resp_op,
   input  logic                 hart_halted,
   input  logic                 hart_running,
   output logic                 haltreq,
   output logic                 resumereq,
   output logic                 resethaltreq,
   output logic                 ndmreset
);

   localparam logic [DMI_ABITS-1:0] A_DATA0      = DMI_ABITS'(7'h04);
   localparam logic [DMI_ABITS-1:0] A_DMCONTROL  = DMI_ABITS'(7'h10);
   localparam logic [DMI_ABITS-1:0] A_DMSTATUS   = DMI_ABITS'(7'h11);
   localparam logic [DMI_ABITS-1:0] A_ABSTRACTCS = DMI_ABITS'(7'h16);
   localparam logic [DMI_ABITS-1:0] A_COMMAND    = DMI_ABITS'(7'h17);

   typedef enum logic {ST_IDLE, ST_RESP} state_e;

   state_e      state_q, state_d;
   logic [31:0] resp_data_q, resp_data_d;
   logic [31:0] data0_q, data0_d;
   logic [9:0]  hartsel_q, hartsel_d;
   logic [2:0]  cmderr_q, cmderr_d;
   logic        dmactive_q, dmactive_d;
   logic        haltreq_q, haltreq_d;
   logic        resume_pend_q, resume_pend_d;
   logic        resumeack_q, resumeack_d;
   logic        rhr_q, rhr_d;
   logic        ndmreset_q, ndmreset_d;
   logic        havereset_q, havereset_d;

   logic        hart_ok;
   logic        accept;
   logic        wr_en;
   logic [31:0] rdata;
   logic [31:0] dmstatus_rd;

   assign hart_ok = (hartsel_q == '0);
   assign accept  = (state_q == ST_IDLE) && dmi_req_valid;
   assign wr_en   = accept && (dmi_req_op == 2'd2);

   // Per-hart status reads as zero whenever the selected hart does not exist.
   always_comb begin
      dmstatus_rd        = '0;
      dmstatus_rd[19:18] = {2{havereset_q & hart_ok}};
      dmstatus_rd[17:16] = {2{resumeack_q & hart_ok}};
      dmstatus_rd[15:14] = {2{~hart_ok}};
      dmstatus_rd[11:10] = {2{hart_running & hart_ok}};
      dmstatus_rd[9:8]   = {2{hart_halted & hart_ok}};
      dmstatus_rd[7]     = 1'b1;
      dmstatus_rd[5]     = 1'b1;
      dmstatus_rd[3:0]   = 4'd2;
   end

   always_comb begin
      rdata = '0;
      case (dmi_req_addr)
         A_DATA0:      rdata = data0_q;
         A_DMCONTROL:  rdata = {haltreq_q, 5'b0, hartsel_q, 14'b0, ndmreset_q, dmactive_q};
         A_DMSTATUS:   rdata = dmstatus_rd;
         A_ABSTRACTCS: rdata = {21'b0, cmderr_q, 8'h01};
         default:      rdata = '0;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      resp_data_d   = resp_data_q;
      data0_d       = data0_q;
      hartsel_d     = hartsel_q;
      cmderr_d      = cmderr_q;
      dmactive_d    = dmactive_q;
      haltreq_d     = haltreq_q;
      resume_pend_d = resume_pend_q;
      resumeack_d   = resumeack_q;
      rhr_d         = rhr_q;
      ndmreset_d    = ndmreset_q;
      havereset_d   = havereset_q;

      case (state_q)
         ST_IDLE: if (dmi_req_valid) begin
            state_d     = ST_RESP;
            resp_data_d = (dmi_req_op == 2'd1) ? rdata : '0;
         end
         ST_RESP: if (dmi_resp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (resume_pend_q && hart_running && !hart_halted) begin
         resume_pend_d = 1'b0;
         resumeack_d   = 1'b1;
      end

      // A register write is applied after hart progress so a new resume request overrides it.
      if (wr_en) begin
         case (dmi_req_addr)
            A_DATA0: if (dmactive_q) data0_d = dmi_req_data;
            A_DMCONTROL: begin
               if (!dmi_req_data[0]) begin
                  dmactive_d    = 1'b0;
                  haltreq_d     = 1'b0;
                  resume_pend_d = 1'b0;
                  resumeack_d   = 1'b0;
                  rhr_d         = 1'b0;
                  ndmreset_d    = 1'b0;
                  hartsel_d     = '0;
                  cmderr_d      = '0;
                  data0_d       = '0;
               end else begin
                  dmactive_d = 1'b1;
                  haltreq_d  = dmi_req_data[31];
                  hartsel_d  = dmi_req_data[25:16];
                  ndmreset_d = dmi_req_data[1];
                  if (dmi_req_data[30] && !dmi_req_data[31]) begin
                     resume_pend_d = 1'b1;
                     resumeack_d   = 1'b0;
                  end
                  if (dmi_req_data[3]) rhr_d = 1'b1;
                  if (dmi_req_data[2]) rhr_d = 1'b0;
                  if (dmi_req_data[28]) havereset_d = 1'b0;
               end
            end
            A_ABSTRACTCS: if (dmactive_q) cmderr_d = cmderr_q & ~dmi_req_data[10:8];
            A_COMMAND:    if (dmactive_q && (cmderr_q == '0)) cmderr_d = 3'd2;
            default: ;
         endcase
      end

      if (ndmreset_d && !ndmreset_q) havereset_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         resp_data_q   <= '0;
         data0_q       <= '0;
         hartsel_q     <= '0;
         cmderr_q      <= '0;
         dmactive_q    <= 1'b0;
         haltreq_q     <= 1'b0;
         resume_pend_q <= 1'b0;
         resumeack_q   <= 1'b0;
         rhr_q         <= 1'b0;
         ndmreset_q    <= 1'b0;
         havereset_q   <= 1'b1;
      end else begin
         state_q       <= state_d;
         resp_data_q   <= resp_data_d;
         data0_q       <= data0_d;
         hartsel_q     <= hartsel_d;
         cmderr_q      <= cmderr_d;
         dmactive_q    <= dmactive_d;
         haltreq_q     <= haltreq_d;
         resume_pend_q <= resume_pend_d;
         resumeack_q   <= resumeack_d;
         rhr_q         <= rhr_d;
         ndmreset_q    <= ndmreset_d;
         havereset_q   <= havereset_d;
      end
   end

   assign dmi_req_ready  = (state_q == ST_IDLE);
   assign dmi_resp_valid = (state_q == ST_RESP);
   assign dmi_resp_data  = resp_data_q;
   assign dmi_resp_op    = 2'b00;
   assign haltreq        = haltreq_q & hart_ok;
   assign resumereq      = resume_pend_q & hart_ok;
   assign resethaltreq   = rhr_q & hart_ok;
   assign ndmreset       = ndmreset_q;

endmodule

// File: tb/tb_debug_module.sv
// Bench for debug_module: transaction-level register model feeding an expected-response queue,
// with a negedge monitor comparing handshake, hart controls and response data.
module tb_debug_module;

   localparam int AW = 7;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [AW-1:0] req_addr = '0;
   logic [31:0]   req_data = '0;
   logic [1:0]    req_op = '0;
   logic          resp_valid;
   logic          resp_ready = 1'b1;
   logic [31:0]   resp_data;
   logic [1:0]    resp_op;
   logic          hart_halted = 1'b0;
   logic          hart_running = 1'b0;
   logic          haltreq, resumereq, resethaltreq, ndmreset;

   int            checks = 0;
   int            errors = 0;
   logic [31:0]   exp_q[$];
   logic [31:0]   last_rd = '0;

   // Reference model: register fields as plain variables, updated once per accepted request.
   bit            m_busy, m_active, m_haltreq, m_pend, m_ack, m_rhr, m_ndm, m_hrst;
   logic [9:0]    m_hartsel;
   logic [2:0]    m_cmderr;
   logic [31:0]   m_data0;

   logic [AW-1:0] addr_tab [8] = '{7'h04, 7'h10, 7'h11, 7'h12, 7'h16, 7'h17, 7'h05, 7'h7f};

   debug_module #(.DMI_ABITS(AW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .dmi_req_valid (req_valid),
      .dmi_req_ready (req_ready),
      .dmi_req_addr  (req_addr),
      .dmi_req_data  (req_data),
      .dmi_req_op    (req_op),
      .dmi_resp_valid(resp_valid),
      .dmi_resp_ready(resp_ready),
      .dmi_resp_data (resp_data),
      .dmi_resp_op   (resp_op),
      .hart_halted   (hart_halted),
      .hart_running  (hart_running),
      .haltreq       (haltreq),
      .resumereq     (resumereq),
      .resethaltreq  (resethaltreq),
      .ndmreset      (ndmreset)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_clear_fields();
      m_active = 0; m_haltreq = 0; m_pend = 0; m_ack = 0; m_rhr = 0; m_ndm = 0;
      m_hartsel = '0; m_cmderr = '0; m_data0 = '0;
   endfunction

   function automatic void model_reset();
      model_clear_fields();
      m_busy = 0;
      m_hrst = 1;
      exp_q.delete();
   endfunction

   function automatic logic [31:0] m_read(input logic [AW-1:0] a);
      logic [31:0] v;
      bit here;
      v = '0;
      here = (m_hartsel == 10'd0);
      case (a)
         7'h04: v = m_data0;
         7'h10: v = {m_haltreq, 5'b0, m_hartsel, 14'b0, m_ndm, m_active};
         7'h11: begin
            v = 32'h0000_00A2;
            if (!here) v = v | 32'h0000_C000;
            else begin
               if (m_hrst)       v = v | 32'h000C_0000;
               if (m_ack)        v = v | 32'h0003_0000;
               if (hart_running) v = v | 32'h0000_0C00;
               if (hart_halted)  v = v | 32'h0000_0300;
            end
         end
         7'h16: v = 32'h1 | {21'b0, m_cmderr, 8'b0};
         default: v = '0;
      endcase
      return v;
   endfunction

   function automatic void m_write(input logic [AW-1:0] a, input logic [31:0] d);
      bit prev_ndm;
      case (a)
         7'h04: if (m_active) m_data0 = d;
         7'h10: begin
            if (!d[0]) model_clear_fields();
            else begin
               prev_ndm  = m_ndm;
               m_active  = 1;
               m_haltreq = d[31];
               m_hartsel = d[25:16];
               m_ndm     = d[1];
               if (d[30] && !d[31]) begin m_pend = 1; m_ack = 0; end
               if (d[3]) m_rhr = 1;
               if (d[2]) m_rhr = 0;
               if (d[28]) m_hrst = 0;
               if (d[1] && !prev_ndm) m_hrst = 1;
            end
         end
         7'h16: if (m_active) m_cmderr = m_cmderr & ~d[10:8];
         7'h17: if (m_active && m_cmderr == 3'd0) m_cmderr = 3'd2;
         default: ;
      endcase
   endfunction

   task automatic model_step();
      bit done, acc;
      acc = 0;
      if (!rst_n) begin
         model_reset();
         return;
      end
      done = m_pend && hart_running && !hart_halted;
      if (m_busy) begin
         if (resp_ready) m_busy = 0;
      end else if (req_valid) begin
         exp_q.push_back(req_op == 2'd1 ? m_read(req_addr) : 32'h0);
         m_busy = 1;
         acc = 1;
      end
      if (done) begin m_pend = 0; m_ack = 1; end
      if (acc && req_op == 2'd2) m_write(req_addr, req_data);
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         model_step();
      end
   end

   // Monitor: every negedge with reset released.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check("req_ready", 32'(req_ready), 32'(!m_busy));
            check("resp_valid", 32'(resp_valid), 32'(m_busy));
            check("haltreq", 32'(haltreq), 32'(m_haltreq && m_hartsel == 10'd0));
            check("resumereq", 32'(resumereq), 32'(m_pend && m_hartsel == 10'd0));
            check("resethaltreq", 32'(resethaltreq), 32'(m_rhr && m_hartsel == 10'd0));
            check("ndmreset", 32'(ndmreset), 32'(m_ndm));
            if (resp_valid && resp_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_resp actual=%h expected=none", resp_data);
               end else begin
                  e = exp_q.pop_front();
                  check("resp_data", resp_data, e);
                  check("resp_op", 32'(resp_op), 32'h0);
                  last_rd = resp_data;
               end
            end
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [31:0] d,
                        input int stall);
      bit ok = 0;
      req_valid = 1; req_op = op; req_addr = a; req_data = d;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (req_ready) ok = 1;
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL accept_timeout actual=not_accepted expected=accepted addr=%h", a);
      end
      @(posedge clk); #1;
      req_valid = 0; req_op = 2'd0;
      if (!ok) return;
      if (stall > 0) begin
         resp_ready = 0;
         repeat (stall) @(posedge clk);
         #1 resp_ready = 1;
      end
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (resp_valid && resp_ready) ok = 1;
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL resp_timeout actual=no_response expected=response addr=%h", a);
      end
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
      issue(2'd2, a, d, 0);
   endtask

   task automatic rd(input logic [AW-1:0] a);
      issue(2'd1, a, 32'h0, 0);
   endtask

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog actual=timeout expected=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      logic [AW-1:0] a;
      logic [31:0]   d;

      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", 32'(req_ready), 32'h1);
      check("rst_resp_valid", 32'(resp_valid), 32'h0);
      check("rst_resp_data", resp_data, 32'h0);
      check("rst_hart_ctrl", {28'h0, haltreq, resumereq, resethaltreq, ndmreset}, 32'h0);
      rst_n = 1;
      @(posedge clk); #1;

      rd(7'h11);
      check("dmstatus_reset", last_rd, 32'h000C_00A2);

      wr(7'h10, 32'h0000_0001);
      wr(7'h10, 32'h8000_0001);
      check("haltreq_set", 32'(haltreq), 32'h1);
      hart_halted = 1;
      rd(7'h11);
      check("halted_bits", 32'(last_rd[9:8]), 32'h3);

      wr(7'h10, 32'h4000_0001);
      check("resumereq_set", 32'(resumereq), 32'h1);
      check("haltreq_clr", 32'(haltreq), 32'h0);
      repeat (3) @(posedge clk);
      #1 hart_halted = 0; hart_running = 1;
      @(negedge clk);
      check("resumereq_hold", 32'(resumereq), 32'h1);
      @(negedge clk);
      check("resumereq_drop", 32'(resumereq), 32'h0);
      @(posedge clk); #1;
      rd(7'h11);
      check("resumeack_bits", 32'(last_rd[17:16]), 32'h3);

      wr(7'h17, 32'h0);
      rd(7'h16);
      check("abstractcs_cmderr", last_rd, 32'h0000_0201);
      wr(7'h16, 32'h0000_0700);
      rd(7'h16);
      check("abstractcs_w1c", last_rd, 32'h0000_0001);

      wr(7'h04, 32'hDEAD_BEEF);
      req_valid = 1; req_op = 2'd1; req_addr = 7'h04; req_data = 32'h0;
      @(negedge clk);
      check("stall_accept_rdy", 32'(req_ready), 32'h1);
      @(posedge clk); #1;
      resp_ready = 0; req_op = 2'd2; req_data = 32'h1234_5678;
      repeat (5) begin
         @(negedge clk);
         check("stall_valid", 32'(resp_valid), 32'h1);
         check("stall_data", resp_data, 32'hDEAD_BEEF);
         check("stall_req_ready", 32'(req_ready), 32'h0);
      end
      @(posedge clk); #1;
      req_valid = 0; req_op = 2'd0; resp_ready = 1;
      repeat (2) @(posedge clk);
      #1;
      rd(7'h04);
      check("data0_kept", last_rd, 32'hDEAD_BEEF);

      wr(7'h10, 32'h8001_0001);
      check("hartsel_haltreq", 32'(haltreq), 32'h0);
      rd(7'h11);
      check("nonexistent_bits", 32'(last_rd[15:14]), 32'h3);
      check("nonexist_masked", 32'(last_rd[19:16]), 32'h0);

      wr(7'h10, 32'h0000_0009);
      check("rhr_set", 32'(resethaltreq), 32'h1);
      wr(7'h10, 32'h0000_000D);
      check("rhr_clr_wins", 32'(resethaltreq), 32'h0);

      wr(7'h10, 32'h1000_0001);
      rd(7'h11);
      check("havereset_ack", 32'(last_rd[19:18]), 32'h0);
      wr(7'h10, 32'h1000_0003);
      rd(7'h11);
      check("havereset_set_wins", 32'(last_rd[19:18]), 32'h3);
      wr(7'h10, 32'h1000_0003);
      rd(7'h11);
      check("havereset_no_edge", 32'(last_rd[19:18]), 32'h0);

      wr(7'h10, 32'h0);
      check("inactive_ndmreset", 32'(ndmreset), 32'h0);
      wr(7'h04, 32'h0000_1234);
      rd(7'h04);
      check("inactive_data0", last_rd, 32'h0);
      wr(7'h17, 32'h0);
      rd(7'h16);
      check("inactive_cmderr", last_rd, 32'h0000_0001);
      wr(7'h10, 32'h0000_0001);

      for (int i = 0; i < 300; i++) begin
         a = addr_tab[$urandom_range(0, 7)];
         d = $urandom;
         if (a == 7'h10 && $urandom_range(0, 3) != 0) d[25:16] = '0;
         if (a == 7'h10 && $urandom_range(0, 7) != 0) d[0] = 1'b1;
         hart_halted  = 1'($urandom_range(0, 1));
         hart_running = 1'($urandom_range(0, 1));
         issue(2'($urandom_range(0, 3)), a, d, $urandom_range(0, 2));
      end

      wr(7'h10, 32'h0000_0003);
      req_valid = 1; req_op = 2'd1; req_addr = 7'h11;
      @(posedge clk); #1;
      req_valid = 0; req_op = 2'd0; resp_ready = 0;
      @(negedge clk);
      check("midresp_valid", 32'(resp_valid), 32'h1);
      @(posedge clk); #1;
      rst_n = 0;
      #1;
      check("rst_drop_valid", 32'(resp_valid), 32'h0);
      check("rst_drop_ready", 32'(req_ready), 32'h1);
      check("rst_drop_data", resp_data, 32'h0);
      check("rst_drop_ctrl", {28'h0, haltreq, resumereq, resethaltreq, ndmreset}, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1; resp_ready = 1;
      @(posedge clk); #1;
      rd(7'h10);
      check("post_rst_dmcontrol", last_rd, 32'h0);
      hart_halted = 0; hart_running = 0;
      rd(7'h11);
      check("post_rst_dmstatus", last_rd, 32'h000C_00A2);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
